// File: rtl/lab4_minterm_sweeper.sv
// lab4_minterm_sweeper
//   Walks a 7-input combinational function through every input vector in
//   ascending order (0 .. 2^N_IN-1), sampling func_in once per vector and
//   accumulating the ones count plus the first and last asserted indices.
//   Optional 16-bit LFSR-style signature of the output stream when the
//   macro LAB4_SWEEP_SIGNATURE_EN is defined.
module lab4_minterm_sweeper #(
   parameter int N_IN  = 7,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic [N_IN-1:0]  vec_out,
   input  logic             func_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] ones_count,
   output logic             any_one,
   output logic [N_IN-1:0]  first_one,
   output logic [N_IN-1:0]  last_one
`ifdef LAB4_SWEEP_SIGNATURE_EN
   ,
   output logic [15:0]      sig
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [N_IN-1:0] VEC_MAX = '1;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_clear;      // accepted start: zero vector and results
   logic             w_sample;     // fold func_in into the results this cycle
   logic             w_last_vec;   // final vector of the sweep is on vec_out

   logic [N_IN-1:0]  r_vec;
   logic [CNT_W-1:0] r_ones;
   logic             r_any;
   logic [N_IN-1:0]  r_first;
   logic [N_IN-1:0]  r_last;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of block order.
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state decode and control strobes; abort outranks the final-vector exit.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_sample     = 1'b0;
      w_last_vec   = (r_vec == VEC_MAX);
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_SWEEP;
               w_clear      = 1'b1;
            end
         end
         S_SWEEP: begin
            if (abort) begin
               w_state_next = S_IDLE;
            end else begin
               w_sample = 1'b1;
               if (w_last_vec) w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_state_next = S_SWEEP;
               w_clear      = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Vector counter: restarts at 0 on start, steps through the sweep, and
   // returns to 0 on abort or after the last vector.
   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         r_vec <= '0;
      end else if (r_state == S_SWEEP) begin
         if (abort || w_last_vec) r_vec <= '0;
         else                     r_vec <= r_vec + 1'b1;
      end
   end

   // Result accumulators: cleared on an accepted start, held otherwise.
   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         r_ones  <= '0;
         r_any   <= 1'b0;
         r_first <= '0;
         r_last  <= '0;
      end else if (w_sample && func_in) begin
         r_ones <= r_ones + 1'b1;
         r_last <= r_vec;
         if (!r_any) begin
            r_first <= r_vec;
            r_any   <= 1'b1;
         end
      end
   end

`ifdef LAB4_SWEEP_SIGNATURE_EN
   logic [15:0] r_sig;

   // Signature shifts in func_in, mixed with taps 15/13/12/10, once per sampled vector.
   always_ff @(posedge clk) begin
      if (reset || w_clear) r_sig <= '0;
      else if (w_sample)    r_sig <= {r_sig[14:0], r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10] ^ func_in};
   end

   assign sig = r_sig;
`endif

   assign vec_out    = r_vec;
   assign busy       = (r_state == S_SWEEP);
   assign done       = (r_state == S_DONE);
   assign ones_count = r_ones;
   assign any_one    = r_any;
   assign first_one  = r_first;
   assign last_one   = r_last;

endmodule

// File: tb/tb_lab4_minterm_sweeper.sv
// Testbench for lab4_minterm_sweeper: expected sweep results are computed by
// a behavioural model, queued when a sweep is launched, and compared when the
// done pulse arrives.
module tb_lab4_minterm_sweeper;

   localparam int N_IN  = 7;
   localparam int CNT_W = 8;
   localparam int NVEC  = 1 << N_IN;

   localparam int M_ZERO = 0;
   localparam int M_ONES = 1;
   localparam int M_ODD  = 2;
   localparam int M_42   = 3;
   localparam int M_MIX  = 4;

   typedef struct {
      logic [CNT_W-1:0] ones;
      logic             any;
      logic [N_IN-1:0]  first;
      logic [N_IN-1:0]  last;
      logic [15:0]      sig;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [N_IN-1:0]  vec_out;
   logic             func_in;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] ones_count;
   logic             any_one;
   logic [N_IN-1:0]  first_one;
   logic [N_IN-1:0]  last_one;
`ifdef LAB4_SWEEP_SIGNATURE_EN
   logic [15:0]      sig;
`endif

   int   mode = M_ZERO;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   lab4_minterm_sweeper #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .vec_out    (vec_out),
      .func_in    (func_in),
      .busy       (busy),
      .done       (done),
      .ones_count (ones_count),
      .any_one    (any_one),
      .first_one  (first_one),
      .last_one   (last_one)
`ifdef LAB4_SWEEP_SIGNATURE_EN
      ,
      .sig        (sig)
`endif
   );

   always #5 clk = ~clk;

   // Function under evaluation, selected by the current test.
   function automatic logic f_model(input int m, input int v);
      case (m)
         M_ONES:  return 1'b1;
         M_ODD:   return v[0];
         M_42:    return (v == 42);
         M_MIX:   return (v % 3 == 0) || (v > 120);
         default: return 1'b0;
      endcase
   endfunction

   always_comb func_in = f_model(mode, int'(vec_out));

   // Reference results of a complete sweep for the given function.
   function automatic exp_t sweep_model(input int m);
      exp_t e;
      logic f;
      e.ones = '0; e.any = 1'b0; e.first = '0; e.last = '0; e.sig = '0;
      for (int v = 0; v < NVEC; v++) begin
         f = f_model(m, v);
         if (f) begin
            e.ones = e.ones + 1'b1;
            if (!e.any) e.first = N_IN'(v);
            e.any  = 1'b1;
            e.last = N_IN'(v);
         end
         e.sig = {e.sig[14:0], e.sig[15] ^ e.sig[13] ^ e.sig[12] ^ e.sig[10] ^ f};
      end
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      step(); step();
      reset = 1'b0;
      n_checks++;
      if (vec_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL reset_ctrl: vec_out=%0d busy=%b done=%b, expected 0/0/0", vec_out, busy, done);
         n_errors++;
      end
      n_checks++;
      if (ones_count !== '0 || any_one !== 1'b0 || first_one !== '0 || last_one !== '0) begin
         $display("FAIL reset_results: ones=%0d any=%b first=%0d last=%0d, expected all 0",
                  ones_count, any_one, first_one, last_one);
         n_errors++;
      end
`ifdef LAB4_SWEEP_SIGNATURE_EN
      n_checks++;
      if (sig !== 16'h0000) begin
         $display("FAIL reset_sig: got %h expected 0000", sig);
         n_errors++;
      end
`endif
   endtask

   // Runs one sweep: optional start pulse, optional ignored start at vector
   // inject_at, and optional start in the DONE cycle to chain the next sweep.
   task automatic run_sweep(input int m, input int inject_at, input bit pre_started, input bit chain);
      exp_t e;
      int   cyc;
      int   busy_cnt;
      mode = m;
      sb_q.push_back(sweep_model(m));
      if (!pre_started) begin
         start = 1'b1;
         step();
         start = 1'b0;
      end
      cyc = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && cyc < 300) begin
         if (busy === 1'b1) busy_cnt++;
         start = (inject_at >= 0 && int'(vec_out) == inject_at) ? 1'b1 : 1'b0;
         step();
         cyc++;
      end
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1) begin
         $display("FAIL sweep_timeout: mode=%0d done never seen within %0d cycles", m, cyc);
         n_errors++;
      end
      n_checks++;
      if (busy_cnt != NVEC || busy !== 1'b0) begin
         $display("FAIL busy_len: mode=%0d busy cycles=%0d busy_at_done=%b, expected %0d and 0",
                  m, busy_cnt, busy, NVEC);
         n_errors++;
      end
      n_checks++;
      if (sb_q.size() == 0) begin
         $display("FAIL scoreboard_empty: mode=%0d no expected entry", m);
         n_errors++;
         e = sweep_model(m);
      end else begin
         e = sb_q.pop_front();
      end
      n_checks++;
      if (ones_count !== e.ones || any_one !== e.any || first_one !== e.first || last_one !== e.last) begin
         $display("FAIL results: mode=%0d got ones=%0d any=%b first=%0d last=%0d, expected ones=%0d any=%b first=%0d last=%0d",
                  m, ones_count, any_one, first_one, last_one, e.ones, e.any, e.first, e.last);
         n_errors++;
      end
      n_checks++;
      if (vec_out !== '0) begin
         $display("FAIL vec_wrap: mode=%0d vec_out=%0d after sweep, expected 0", m, vec_out);
         n_errors++;
      end
`ifdef LAB4_SWEEP_SIGNATURE_EN
      n_checks++;
      if (sig !== e.sig) begin
         $display("FAIL signature: mode=%0d got %h expected %h", m, sig, e.sig);
         n_errors++;
      end
`endif
      if (chain) begin
         start = 1'b1;
         step();
         start = 1'b0;
         n_checks++;
         if (busy !== 1'b1 || ones_count !== '0 || vec_out !== '0) begin
            $display("FAIL restart_from_done: busy=%b ones=%0d vec=%0d, expected 1/0/0", busy, ones_count, vec_out);
            n_errors++;
         end
      end else begin
         step();
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0 || ones_count !== e.ones || last_one !== e.last) begin
            $display("FAIL post_done_hold: done=%b busy=%b ones=%0d last=%0d, expected 0/0/%0d/%0d",
                     done, busy, ones_count, last_one, e.ones, e.last);
            n_errors++;
         end
      end
   endtask

   task automatic test_patterns();
      run_sweep(M_ZERO, -1, 1'b0, 1'b0);
      run_sweep(M_ONES, -1, 1'b0, 1'b0);
      run_sweep(M_ODD,  -1, 1'b0, 1'b0);
      run_sweep(M_42,   -1, 1'b0, 1'b0);
      run_sweep(M_MIX,  -1, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      exp_t e;
      int   cyc;
      bit   saw_done;
      mode = M_ONES;
      e.ones = 8'd10; e.any = 1'b1; e.first = '0; e.last = 7'd9; e.sig = '0;
      sb_q.push_back(e);
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (int'(vec_out) != 10 && cyc < 200) begin
         step();
         cyc++;
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      e = sb_q.pop_front();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_out !== '0) begin
         $display("FAIL abort_state: busy=%b done=%b vec=%0d, expected 0/0/0", busy, done, vec_out);
         n_errors++;
      end
      n_checks++;
      if (ones_count !== e.ones || any_one !== e.any || first_one !== e.first || last_one !== e.last) begin
         $display("FAIL abort_partial: got ones=%0d any=%b first=%0d last=%0d, expected %0d/%b/%0d/%0d",
                  ones_count, any_one, first_one, last_one, e.ones, e.any, e.first, e.last);
         n_errors++;
      end
      saw_done = 1'b0;
      for (int i = 0; i < 140; i++) begin
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
         step();
      end
      n_checks++;
      if (saw_done) begin
         $display("FAIL abort_no_done: done or busy seen after abort, expected idle");
         n_errors++;
      end
      run_sweep(M_ONES, -1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int cyc;
      mode = M_ONES;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (int'(vec_out) != 50 && cyc < 200) begin
         step();
         cyc++;
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || vec_out !== '0 || ones_count !== '0 ||
          any_one !== 1'b0 || first_one !== '0 || last_one !== '0) begin
         $display("FAIL reset_mid: busy=%b done=%b vec=%0d ones=%0d any=%b first=%0d last=%0d, expected all 0",
                  busy, done, vec_out, ones_count, any_one, first_one, last_one);
         n_errors++;
      end
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL reset_mid_idle: busy=%b done=%b, expected 0/0", busy, done);
         n_errors++;
      end
   endtask

   task automatic test_start_ignored();
      run_sweep(M_ODD, 5, 1'b0, 1'b0);
   endtask

   task automatic test_start_abort_idle();
      mode = M_42;
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || vec_out !== '0) begin
         $display("FAIL start_abort_idle: busy=%b vec=%0d, expected 1/0", busy, vec_out);
         n_errors++;
      end
      run_sweep(M_42, -1, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_sweep(M_ONES, -1, 1'b0, 1'b1);
      run_sweep(M_42,   -1, 1'b1, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      test_reset();
      test_patterns();
      test_abort();
      test_reset_mid();
      test_start_ignored();
      test_start_abort_idle();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lab4_minterm_sweeper.md
Name: lab4_minterm_sweeper

Overview:
- Sequencer that exhaustively drives a 7-input combinational boolean function through all 128 input vectors (0 to 127, ascending).
- Samples the function's output for each vector and accumulates results: ones count, first and last asserted index, and an optional signature.
- Sits between the lab top level (start/abort controls, status display) and the combinational minterm block under evaluation.

Parameters:
- N_IN, 7, number of function inputs; sweep length is 2^N_IN.
- CNT_W, 8, ones_count width; must hold 2^N_IN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; honoured only in IDLE or DONE
- abort  input  1  cancel an in-progress sweep
- vec_out  output  N_IN  vector applied to the function; bit0 = a … bit6 = g
- func_in  input  1  function output for the current vec_out (combinational return path)
- busy  output  1  high while in SWEEP
- done  output  1  one-cycle pulse when a sweep completes
- ones_count  output  CNT_W  number of vectors with func_in = 1
- any_one  output  1  at least one vector produced 1
- first_one  output  N_IN  lowest vector index with func_in = 1
- last_one  output  N_IN  highest vector index with func_in = 1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; vec_out, ones_count, first_one and last_one all 0; busy, done and any_one all 0.
- Reset mid-sweep overrides everything and returns to IDLE on the next edge.
- States: IDLE, SWEEP, DONE.
- IDLE + start:
  - go to SWEEP.
  - vec_out = 0; ones_count, any_one, first_one and last_one are cleared on the same edge.
- SWEEP, each cycle:
  - func_in is sampled for the vec_out currently driven.
  - If func_in = 1: ones_count += 1 and last_one = vec_out. If any_one = 0, also set first_one = vec_out and any_one = 1.
  - If vec_out ≠ 2^N_IN − 1: vec_out increments.
  - If vec_out = 2^N_IN − 1: sample, go to DONE, and vec_out wraps to 0.
- Timing: exactly 2^N_IN (128) SWEEP cycles. busy is high for all of them.
- done: asserted for exactly the one cycle spent in DONE, i.e. 129 cycles after the start edge.
- DONE: next cycle go to IDLE; start in DONE behaves as in IDLE.
- Results hold after DONE until the next accepted start.
- start during SWEEP is ignored; the sweep is not restarted.
- abort in SWEEP: go to IDLE next edge with no done pulse, vec_out = 0, partial results retained. abort has priority over the final-vector transition. abort outside SWEEP has no effect.
- start and abort together in IDLE: start wins, because abort is ignored outside SWEEP.
- ones_count saturating is not required; the maximum 128 fits in CNT_W = 8.
- func_in must settle within one clock period of a vec_out change; there is no internal synchronizer.

Optional Feature:
- Macro: LAB4_SWEEP_SIGNATURE_EN
- Enabled:
  - Adds output sig (16 bits).
  - Cleared on start, reset value 0x0000.
  - Each SWEEP cycle: sig = {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10] ^ func_in}.
  - Held after DONE; abort retains its value.
- Disabled: port and register absent; all other behaviour identical.

Test Plan:
- Reset, then pulse start with func_in tied 0 → busy high for 128 cycles, done pulse at cycle 129; ones_count = 0, any_one = 0, first_one = 0, last_one = 0.
- func_in tied 1 → ones_count = 128, first_one = 0, last_one = 127, any_one = 1; vec_out = 0 after DONE.
- func_in = vec_out[0] → ones_count = 64, first_one = 1, last_one = 127; with signature enabled, sig matches the model value for the alternating 0,1,… stream.
- func_in = (vec_out == 42) → ones_count = 1, first_one = 42, last_one = 42.
- Start sweep, abort at vec_out = 10 with func_in tied 1 → next cycle IDLE, no done, ones_count = 10, last_one = 9. Start again → full 128-cycle sweep, ones_count = 128.
- Reset asserted at vec_out = 50 → IDLE, all outputs 0. start pulsed during SWEEP at vec_out = 5 → ignored, done still arrives 129 cycles after the original start.
